// File: rtl/trng_pkg.sv
// Shared types and default widths for the TRNG entropy source blocks.
package trng_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } ro_sampler_state_t;

    localparam int TRNG_WORD_W = 32;
    localparam int TRNG_NUM_RO = 8;

endpackage

// File: rtl/ro_sync.sv
// N-bit two-flop synchronizer for asynchronous oscillator outputs.
module ro_sync #(
    parameter int N = 1
) (
    input  logic         clk_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    (* ASYNC_REG = "TRUE" *) logic [N-1:0] s1_q;
    (* ASYNC_REG = "TRUE" *) logic [N-1:0] s2_q;

    always_ff @(posedge clk_i) begin
        s1_q <= d_i;
        s2_q <= s1_q;
    end

    assign q_o = s2_q;

endmodule

// File: rtl/ro_sampler.sv
// Ring oscillator sampler: XOR-combined raw bits packed into words on a valid/ready stream.
// Define RO_SAMPLER_VN_EN to insert a von Neumann corrector ahead of the shift register.
module ro_sampler
    import trng_pkg::*;
#(
    parameter int NUM_RO = TRNG_NUM_RO,
    parameter int WORD_W = TRNG_WORD_W,
    parameter int DIV_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic [NUM_RO-1:0] ro_in_i,
    output logic [NUM_RO-1:0] ro_ctrl_o,
    output logic [WORD_W-1:0] rnd_data_o,
    output logic              rnd_valid_o,
    input  logic              rnd_ready_i
);

    localparam int BC_W = $clog2(WORD_W);

    ro_sampler_state_t state_q, state_d;
    logic [DIV_W-1:0]  dcnt_q, dcnt_d, div_q, div_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d, data_q, data_d;
    logic [NUM_RO-1:0] ctrl_q, ctrl_d;
    logic              valid_q, valid_d;

    logic [NUM_RO-1:0] ro_sync_w;
    logic              raw_bit, wrap, tick, hs, load, bit_vld, bit_val;
    logic [WORD_W-1:0] word, load_word;

    ro_sync #(.N(NUM_RO)) u_sync (
        .clk_i (clk_i),
        .d_i   (ro_in_i),
        .q_o   (ro_sync_w)
    );

    assign raw_bit = ^ro_sync_w;
    assign wrap    = (dcnt_q == div_q);
    assign tick    = en_i && (state_q == COLLECT) && wrap;
    assign hs      = valid_q && rnd_ready_i;
    assign word    = {shreg_q[WORD_W-2:0], bit_val};

`ifdef RO_SAMPLER_VN_EN
    logic vn_ph_q, vn_ph_d, vn_first_q, vn_first_d;

    // Pairs 01 -> 0 and 10 -> 1 emit the first bit of the pair; equal pairs are dropped.
    always_comb begin
        vn_ph_d    = vn_ph_q;
        vn_first_d = vn_first_q;
        bit_vld    = 1'b0;
        bit_val    = vn_first_q;
        if (!en_i) begin
            vn_ph_d    = 1'b0;
            vn_first_d = 1'b0;
        end else if (tick) begin
            if (!vn_ph_q) begin
                vn_ph_d    = 1'b1;
                vn_first_d = raw_bit;
            end else begin
                vn_ph_d = 1'b0;
                bit_vld = vn_first_q ^ raw_bit;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            vn_ph_q    <= 1'b0;
            vn_first_q <= 1'b0;
        end else begin
            vn_ph_q    <= vn_ph_d;
            vn_first_q <= vn_first_d;
        end
    end
`else
    assign bit_vld = tick;
    assign bit_val = raw_bit;
`endif

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        div_d     = div_q;
        bcnt_d    = bcnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        ctrl_d    = ctrl_q;
        valid_d   = valid_q && !hs;
        load      = 1'b0;
        load_word = word;
        if (!en_i) begin
            state_d = IDLE;
            dcnt_d  = '0;
            bcnt_d  = '0;
            shreg_d = '0;
            div_d   = div_i;
        end else begin
            case (state_q)
                IDLE: state_d = COLLECT;
                COLLECT: begin
                    if (bit_vld) begin
                        if (bcnt_q == BC_W'(WORD_W - 1)) begin
                            bcnt_d = '0;
                            if (!valid_q || hs) begin
                                load    = 1'b1;
                                shreg_d = '0;
                            end else begin
                                shreg_d = word;
                                state_d = HOLD;
                            end
                        end else begin
                            bcnt_d  = bcnt_q + 1'b1;
                            shreg_d = word;
                        end
                    end
                end
                HOLD: begin
                    if (hs) begin
                        load      = 1'b1;
                        load_word = shreg_q;
                        shreg_d   = '0;
                        state_d   = COLLECT;
                    end
                end
                default: state_d = IDLE;
            endcase
            // The divider keeps running from the first enabled cycle, frozen only while a word waits.
            if (state_q != HOLD) begin
                dcnt_d = wrap ? '0 : dcnt_q + 1'b1;
                if (wrap) div_d = div_i;
            end
        end
        if (load) begin
            data_d  = load_word;
            valid_d = 1'b1;
            ctrl_d  = load_word[NUM_RO-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
            div_q   <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            div_q   <= div_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    assign ro_ctrl_o   = ctrl_q;
    assign rnd_data_o  = data_q;
    assign rnd_valid_o = valid_q;

endmodule

// File: tb/tb_ro_sampler.sv
// Directed self-checking bench for ro_sampler (NUM_RO=2, WORD_W=8).
module tb_ro_sampler;
    import trng_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] div;
    logic [1:0] ro_in;
    logic [1:0] ro_ctrl;
    logic [7:0] rnd_data;
    logic       rnd_valid;
    logic       rnd_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ro_sampler #(.NUM_RO(2), .WORD_W(8), .DIV_W(8)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .en_i        (en),
        .div_i       (div),
        .ro_in_i     (ro_in),
        .ro_ctrl_o   (ro_ctrl),
        .rnd_data_o  (rnd_data),
        .rnd_valid_o (rnd_valid),
        .rnd_ready_i (rnd_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (4) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; div = 8'd0; ro_in = 2'b01; rnd_ready = 1'b1;
        repeat (3) step();
        checks++; if (rnd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rnd_valid); end
        checks++; if (rnd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rnd_data); end
        checks++; if (ro_ctrl !== 2'b00) begin errors++; $display("FAIL reset_ctrl: got %b expected 00", ro_ctrl); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_ones();
        logic exp_v;
        logic [1:0] exp_c;
        div = 8'd0; ro_in = 2'b01; rnd_ready = 1'b1;
        do_reset();
        en = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            exp_v = (c >= 10) && ((c - 10) % 8 == 0);
            exp_c = (c >= 10) ? 2'b11 : 2'b00;
            checks++; if (rnd_valid !== exp_v) begin errors++; $display("FAIL ones_valid c=%0d: got %b expected %b", c, rnd_valid, exp_v); end
            checks++; if (ro_ctrl !== exp_c) begin errors++; $display("FAIL ones_ctrl c=%0d: got %b expected %b", c, ro_ctrl, exp_c); end
            if (exp_v) begin
                checks++; if (rnd_data !== 8'hFF) begin errors++; $display("FAIL ones_data c=%0d: got %h expected FF", c, rnd_data); end
            end
            step();
        end
        en = 1'b0;
    endtask

    task automatic test_zeros();
        div = 8'd0; ro_in = 2'b11; rnd_ready = 1'b1;
        do_reset();
        en = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            if (c == 9 || c == 10 || c == 11) begin
                checks++; if (rnd_valid !== (c == 10)) begin errors++; $display("FAIL zeros_valid c=%0d: got %b expected %b", c, rnd_valid, c == 10); end
            end
            if (c == 10) begin
                checks++; if (rnd_data !== 8'h00) begin errors++; $display("FAIL zeros_data: got %h expected 00", rnd_data); end
            end
            if (c == 12) begin
                checks++; if (ro_ctrl !== 2'b00) begin errors++; $display("FAIL zeros_ctrl: got %b expected 00", ro_ctrl); end
            end
            step();
        end
        en = 1'b0;
    endtask

    task automatic test_div();
        int first = 0;
        int second = 0;
        logic [7:0] first_data = 8'h00;
        div = 8'd3; ro_in = 2'b01; rnd_ready = 1'b1;
        do_reset();
        en = 1'b1;
        for (int c = 1; c <= 80 && second == 0; c++) begin
            if (rnd_valid === 1'b1) begin
                if (first == 0) begin first = c; first_data = rnd_data; end
                else second = c;
            end
            step();
        end
        checks++; if (first != 33) begin errors++; $display("FAIL div_first: got cycle %0d expected 33", first); end
        checks++; if (second != 65) begin errors++; $display("FAIL div_second: got cycle %0d expected 65", second); end
        checks++; if (first_data !== 8'hFF) begin errors++; $display("FAIL div_data: got %h expected FF", first_data); end
        en = 1'b0;
        div = 8'd0;
    endtask

    task automatic test_back_to_back();
        div = 8'd0; ro_in = 2'b01; rnd_ready = 1'b0;
        do_reset();
        en = 1'b1;
        for (int c = 1; c <= 35; c++) begin
            if (c == 8) ro_in = 2'b11;
            if (c >= 10 && c <= 25) begin
                checks++; if (rnd_valid !== 1'b1 || rnd_data !== 8'hFF) begin errors++; $display("FAIL hold_word1 c=%0d: got v=%b d=%h expected v=1 d=FF", c, rnd_valid, rnd_data); end
            end
            if (c == 20 || c == 25) begin
                checks++; if (dut.state_q !== HOLD) begin errors++; $display("FAIL hold_state c=%0d: got %0d expected %0d", c, dut.state_q, HOLD); end
            end
            if (c == 25) rnd_ready = 1'b1;
            if (c == 26) begin
                checks++; if (rnd_valid !== 1'b1 || rnd_data !== 8'h00) begin errors++; $display("FAIL hold_word2: got v=%b d=%h expected v=1 d=00", rnd_valid, rnd_data); end
                checks++; if (ro_ctrl !== 2'b00) begin errors++; $display("FAIL hold_ctrl: got %b expected 00", ro_ctrl); end
                checks++; if (dut.state_q !== COLLECT) begin errors++; $display("FAIL hold_resume: got %0d expected %0d", dut.state_q, COLLECT); end
            end
            if (c == 27 || c == 33) begin
                checks++; if (rnd_valid !== 1'b0) begin errors++; $display("FAIL hold_gap c=%0d: got %b expected 0", c, rnd_valid); end
            end
            if (c == 34) begin
                checks++; if (rnd_valid !== 1'b1 || rnd_data !== 8'h00) begin errors++; $display("FAIL hold_word3: got v=%b d=%h expected v=1 d=00", rnd_valid, rnd_data); end
            end
            step();
        end
        en = 1'b0;
    endtask

    task automatic test_mid_reset();
        div = 8'd0; ro_in = 2'b01; rnd_ready = 1'b0;
        do_reset();
        en = 1'b1;
        for (int c = 1; c < 15; c++) step();
        checks++; if (rnd_valid !== 1'b1 || rnd_data !== 8'hFF || ro_ctrl !== 2'b11) begin errors++; $display("FAIL midrst_pre: got v=%b d=%h c=%b expected v=1 d=FF c=11", rnd_valid, rnd_data, ro_ctrl); end
        rst_n = 1'b0;
        step();
        checks++; if (rnd_valid !== 1'b0 || rnd_data !== 8'h00 || ro_ctrl !== 2'b00) begin errors++; $display("FAIL midrst_out: got v=%b d=%h c=%b expected all 0", rnd_valid, rnd_data, ro_ctrl); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL midrst_state: got %0d expected %0d", dut.state_q, IDLE); end
        rst_n = 1'b1;
        en = 1'b0;
        step();
    endtask

    task automatic test_mid_disable();
        div = 8'd0; ro_in = 2'b01; rnd_ready = 1'b1;
        do_reset();
        en = 1'b1;
        for (int c = 1; c < 7; c++) step();
        en = 1'b0;
        ro_in = 2'b11;
        repeat (3) step();
        en = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            if (c == 9 || c == 11) begin
                checks++; if (rnd_valid !== 1'b0) begin errors++; $display("FAIL middis_valid c=%0d: got %b expected 0", c, rnd_valid); end
            end
            if (c == 10) begin
                checks++; if (rnd_valid !== 1'b1 || rnd_data !== 8'h00) begin errors++; $display("FAIL middis_word: got v=%b d=%h expected v=1 d=00", rnd_valid, rnd_data); end
            end
            step();
        end
        en = 1'b0;
    endtask

`ifdef RO_SAMPLER_VN_EN
    task automatic test_vn();
        int seen = 0;
        div = 8'd0; ro_in = 2'b00; rnd_ready = 1'b1;
        do_reset();
        en = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            ro_in = {1'b0, c[0]};
            if (c == 17) begin
                checks++; if (rnd_valid !== 1'b0) begin errors++; $display("FAIL vn_early: got %b expected 0", rnd_valid); end
            end
            if (c == 18) begin
                checks++; if (rnd_valid !== 1'b1 || rnd_data !== 8'h00) begin errors++; $display("FAIL vn_word: got v=%b d=%h expected v=1 d=00", rnd_valid, rnd_data); end
            end
            step();
        end
        en = 1'b0;
        ro_in = 2'b01;
        do_reset();
        en = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            if (rnd_valid === 1'b1) seen++;
            step();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL vn_const: got %0d valid cycles expected 0", seen); end
        en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_ones();
        test_zeros();
        test_div();
        test_back_to_back();
        test_mid_reset();
        test_mid_disable();
`ifdef RO_SAMPLER_VN_EN
        test_vn();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ro_sampler.md
# ro_sampler

Samples a bank of free-running ring oscillators into the system clock domain and XOR-combines them into one raw bit per sample tick. Packs the bits into `WORD_W`-bit words and presents them on a valid/ready stream to the TRNG post-processing and readout logic. It also drives the per-oscillator `ctrl` inputs, which select the stage parity, so the oscillator bank is re-perturbed after every word.

## Interface
- `NUM_RO`, 8: number of ring oscillators sampled; must satisfy `NUM_RO <= WORD_W`.
- `WORD_W`, 32: output word width in bits.
- `DIV_W`, 8: width of the sample-period divider.
- `clk`  in  1: system clock; the only clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `en`  in  1: collection enable.
- `div`  in  DIV_W: sample period; one tick every `div+1` cycles.
- `ro_in`  in  NUM_RO: asynchronous ring oscillator outputs.
- `ro_ctrl`  out  NUM_RO: parity control to each oscillator; reset value 0.
- `rnd_data`  out  WORD_W: output word; reset value 0.
- `rnd_valid`  out  1: word available; reset value 0.
- `rnd_ready`  in  1: consumer accepts the word.

## Operation
- Each `ro_in` bit passes through a two-flop synchronizer: 2-cycle latency, no reset dependence on the data path.
- Divider counter `dcnt` counts 0..`div`. A tick fires in the cycle `dcnt==div`, and `dcnt` then returns to 0. With `div=0`, every cycle is a tick.
- Raw bit = XOR reduction of the synchronized vector, taken on a tick.
- Accepted bits shift into the shift register LSB-side: `shreg <= {shreg[WORD_W-2:0], bit}`. Bit counter `bcnt` runs 0..`WORD_W-1`.
- Words complete when the `WORD_W`-th bit is accepted.
- States:
  - IDLE: `en=0`; `dcnt`, `bcnt` and `shreg` are held at 0; the output register is untouched.
  - COLLECT: ticks accepted.
  - HOLD: `shreg` full while the output register is still occupied; ticks ignored and `dcnt` frozen.
- Transitions:
  - IDLE→COLLECT on `en=1`.
  - COLLECT→HOLD on word completion with `rnd_valid=1` and no handshake in the same cycle.
  - HOLD→COLLECT in the cycle after a handshake, loading `shreg` into `rnd_data`.
  - Any state→IDLE on `en=0`: clears `dcnt` and `bcnt` and drops any partial or held word. A pending `rnd_data/rnd_valid` is kept until it is accepted.
- Output load: `rnd_data <= word` and `rnd_valid <= 1` when the output register is empty or handshaking in the same cycle. `rnd_valid` falls only on `rnd_valid && rnd_ready` with no simultaneous load.
- `ro_ctrl <= word[NUM_RO-1:0]` at every load into `rnd_data`.
- `div` is sampled when `dcnt` wraps; a change takes effect on the next period.

## Timing
- First tick is 1 cycle after `en` rises. Each bit reflects `ro_in` as it stood 2 cycles before its tick.
- `rnd_valid` rises in the cycle after the completing tick, provided the output register is free.
- A handshake and a new load in the same cycle keep `rnd_valid=1` with the new data, giving zero-bubble back-to-back words.
- `rst_n=0` at any point, including mid-word or during HOLD: all state and outputs return to reset values on the next edge.
- `rnd_data` must not change while `rnd_valid=1` and `rnd_ready=0`.

## Configuration
- `RO_SAMPLER_VN_EN` defined: a von Neumann corrector sits between the raw bit and the shift register.
  - Raw bits pair in tick order: `01`→0, `10`→1, `00` and `11` are discarded.
  - The pair phase clears on IDLE and on reset.
  - Throughput becomes data dependent; `bcnt` advances only on emitted bits.
- Undefined: every raw bit goes directly to the shift register; no pair register exists.

## Structure
- Package `trng_pkg`:
  - state enum `ro_sampler_state_t` (IDLE, COLLECT, HOLD);
  - default width constants `TRNG_WORD_W` and `TRNG_NUM_RO`.
- Sub-module `ro_sync`: parameterized `N`-bit two-flop synchronizer, instantiated once for `ro_in`. Sync flops carry the async-register attribute.

## Test plan
- `NUM_RO=2`, `WORD_W=8`, `div=0`, `ro_in=2'b01` constant, `rnd_ready=1`, `en=1` → `rnd_data=8'hFF` with a one-cycle `rnd_valid` pulse every 8 cycles; `ro_ctrl=2'b11` after the first word.
- Same setup with `ro_in=2'b11` → `rnd_data=8'h00`, `ro_ctrl` stays `2'b00`.
- `div=3`, `ro_in=2'b01` → first `rnd_valid` rises at cycle 33 after `en` (cycle 1 = first cycle with `en=1`); following words come every 32 cycles.
- `rnd_ready=0` over two words → first word stable, state HOLD, no further ticks. Raise `rnd_ready` → first word accepted, second word presented the next cycle, then collection resumes.
- Mid-word events:
  - `rst_n=0` after 5 bits → all outputs 0;
  - `en=0` after 5 bits → partial word lost; the next word needs 8 fresh bits.
- With `RO_SAMPLER_VN_EN`:
  - raw pattern 0,1 repeating → `8'h00` after 16 ticks;
  - constant raw 1 → `rnd_valid` never asserts.
